// File: rtl/psum_buf_port_ctrl.sv
// rtl/psum_buf_port_ctrl.sv - port controller for the 8-entry occupancy-tracked psum buffer
module psum_buf_port_ctrl #(
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              sram_CEN,
  output logic              sram_WEN,
  output logic [2:0]        sram_A,
  output logic [DATA_W-1:0] sram_D,
  input  logic [DATA_W-1:0] sram_Q,
  input  logic              sram_full,
  input  logic              sram_almost_full,
  output logic [3:0]        count,
  output logic              err
);

  logic [2:0]        wr_ptr;
  logic [2:0]        rd_ptr;
  logic              prio_rd;
  logic              rd_pend;
  logic [1:0]        occ;
  logic [DATA_W-1:0] q0;
  logic [DATA_W-1:0] q1;
  logic [2:0]        a_hold;

  logic rd_elig;
  logic wr_elig;
  logic wr_gnt;
  logic rd_gnt;
  logic contended;
  logic push;
  logic pop;

  // The 7-of-8 flag carries no control meaning here; it is only observed.
  logic unused_flags;
  assign unused_flags = sram_almost_full;

  // Credit counts the read already in flight so the out queue never overflows.
  assign rd_elig   = (count != 4'd0) && (({1'b0, occ} + {2'b00, rd_pend}) < 3'd2);
  assign wr_elig   = (count < 4'd8);
  assign in_ready  = !rst && wr_elig && !(rd_elig && prio_rd);
  assign wr_gnt    = in_valid && in_ready;
  assign rd_gnt    = !rst && rd_elig && !wr_gnt;
  assign contended = !rst && in_valid && wr_elig && rd_elig;

  assign sram_CEN  = !(wr_gnt || rd_gnt);
  assign sram_WEN  = !wr_gnt;
  assign sram_A    = wr_gnt ? wr_ptr : (rd_gnt ? rd_ptr : a_hold);
  assign sram_D    = in_data;

  assign out_valid = (occ != 2'd0);
  assign out_data  = q0;
  assign push      = rd_pend;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr  <= 3'd0;
      rd_ptr  <= 3'd0;
      count   <= 4'd0;
      prio_rd <= 1'b0;
      rd_pend <= 1'b0;
      a_hold  <= 3'd0;
    end else begin
      rd_pend <= rd_gnt;
      if (contended) prio_rd <= !prio_rd;
      if (wr_gnt) begin
        wr_ptr <= wr_ptr + 3'd1;
        count  <= count + 4'd1;
        a_hold <= wr_ptr;
      end else if (rd_gnt) begin
        rd_ptr <= rd_ptr + 3'd1;
        count  <= count - 4'd1;
        a_hold <= rd_ptr;
      end
    end
  end

  // Two-entry output queue; q0 is always the head.
  always_ff @(posedge CLK) begin
    if (rst) begin
      occ <= 2'd0;
      q0  <= '0;
      q1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) q0 <= sram_Q;
          else             q1 <= sram_Q;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          q0  <= q1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            q0 <= sram_Q;
          end else begin
            q0 <= q1;
            q1 <= sram_Q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      err <= 1'b0;
    end else if (sram_full != (count == 4'd8)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_buf_port_ctrl.sv
// tb/tb_psum_buf_port_ctrl.sv - directed self-checking bench with buffer model and FIFO scoreboard
module tb_psum_buf_port_ctrl;

  localparam int DW = 128;

  logic          CLK = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          sram_CEN;
  logic          sram_WEN;
  logic [2:0]    sram_A;
  logic [DW-1:0] sram_D;
  logic [DW-1:0] sram_Q;
  logic          sram_full;
  logic          sram_almost_full;
  logic [3:0]    count;
  logic          err;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = !CLK;

  psum_buf_port_ctrl #(.DATA_W(DW)) dut (
    .CLK(CLK), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sram_CEN(sram_CEN), .sram_WEN(sram_WEN), .sram_A(sram_A), .sram_D(sram_D),
    .sram_Q(sram_Q), .sram_full(sram_full), .sram_almost_full(sram_almost_full),
    .count(count), .err(err)
  );

  // Behavioural buffer: 8 entries, registered read data, own occupancy count.
  logic [DW-1:0] mem [8];
  int            buf_occ;
  always @(posedge CLK) begin
    if (rst) begin
      buf_occ <= 0;
    end else if (!sram_CEN) begin
      if (!sram_WEN) begin
        mem[sram_A] <= sram_D;
        buf_occ     <= buf_occ + 1;
      end else begin
        sram_Q  <= mem[sram_A];
        buf_occ <= buf_occ - 1;
      end
    end
  end
  assign sram_full        = (buf_occ == 8);
  assign sram_almost_full = (buf_occ == 7);

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted entries must come out in order; accesses must follow FIFO addressing.
  logic [DW-1:0] exp_q[$];
  int            acc_n, pop_n, outside;
  logic [2:0]    exp_wa, exp_ra;
  always @(negedge CLK) begin
    if (rst) begin
      exp_q.delete();
      acc_n  = 0;
      pop_n  = 0;
      exp_wa = 3'd0;
      exp_ra = 3'd0;
    end else begin
      outside = acc_n - pop_n - int'(count);
      chk("count_vs_buffer", DW'(count), DW'(buf_occ));
      chk("err_clear", DW'(err), '0);
      chk("outside_le_2", DW'(outside >= 0 && outside <= 2), DW'(1));
      if (count == 4'd8) chk("full_blocks_in", DW'(in_ready), '0);
      if (!sram_CEN && sram_WEN) begin
        chk("rd_addr", DW'(sram_A), DW'(exp_ra));
        chk("rd_nonempty", DW'(buf_occ > 0), DW'(1));
        exp_ra = exp_ra + 3'd1;
      end
      if (!sram_CEN && !sram_WEN) chk("wr_has_handshake", DW'(in_valid && in_ready), DW'(1));
      if (out_valid && out_ready) begin
        chk("pop_nonempty", DW'(exp_q.size() > 0), DW'(1));
        if (exp_q.size() > 0) begin
          chk("out_order", out_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
        pop_n++;
      end
      if (in_valid && in_ready) begin
        chk("wr_pins", DW'({sram_CEN, sram_WEN}), '0);
        chk("wr_addr", DW'(sram_A), DW'(exp_wa));
        chk("wr_data", sram_D, in_data);
        exp_q.push_back(in_data);
        exp_wa = exp_wa + 3'd1;
        acc_n++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int sent, rx;
  int op, prev_op;
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_in_ready", DW'(in_ready), '0);
    chk("rst_cen", DW'(sram_CEN), DW'(1));
    chk("rst_wen", DW'(sram_WEN), DW'(1));
    chk("rst_count", DW'(count), '0);
    chk("rst_err", DW'(err), '0);
    rst = 1'b0;
    step();

    // Single entry: three cycles from write to out_valid.
    out_ready = 1'b1; in_valid = 1'b1; in_data = DW'(8'hA5);
    #1 chk("t1_in_ready", DW'(in_ready), DW'(1));
    step();
    in_valid = 1'b0;
    #1 chk("t1_count_1", DW'(count), DW'(1));
    chk("t1_nv_1", DW'(out_valid), '0);
    step();
    chk("t1_count_0", DW'(count), '0);
    chk("t1_nv_2", DW'(out_valid), '0);
    step();
    chk("t1_valid", DW'(out_valid), DW'(1));
    chk("t1_data", out_data, DW'(8'hA5));
    step();
    chk("t1_popped", DW'(out_valid), '0);

    // Fill with a stalled consumer: 8 in the buffer plus 2 in the out queue.
    out_ready = 1'b0; sent = 0;
    for (int c = 0; c < 100 && sent < 10; c++) begin
      in_valid = 1'b1; in_data = DW'(sent);
      #1 if (in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    chk("t2_sent", DW'(sent), DW'(10));
    step(); step(); step();
    chk("t2_count", DW'(count), DW'(8));
    chk("t2_full", DW'(sram_full), DW'(1));
    chk("t2_in_ready", DW'(in_ready), '0);
    chk("t2_head_valid", DW'(out_valid), DW'(1));
    chk("t2_head", out_data, '0);
    chk("t2_err", DW'(err), '0);

    // Drain: 0..9 in order across the pointer wrap.
    out_ready = 1'b1; rx = 0;
    for (int c = 0; c < 60 && rx < 10; c++) begin
      #1 if (out_valid) begin
        chk("t3_data", out_data, DW'(rx));
        rx++;
      end
      step();
    end
    chk("t3_rx", DW'(rx), DW'(10));
    step(); step();
    chk("t3_empty", DW'(count), '0);

    // Continuous contention: accesses settle into strict R/W alternation.
    out_ready = 1'b1; sent = 0; prev_op = 0;
    for (int c = 0; c < 24; c++) begin
      in_valid = 1'b1; in_data = DW'(32'h100 + sent);
      #1 op = sram_CEN ? 0 : (sram_WEN ? 1 : 2);
      if (in_ready) sent++;
      if (c >= 6) begin
        chk("t4_no_idle", DW'(op != 0), DW'(1));
        chk("t4_alternate", DW'(op != prev_op), DW'(1));
      end
      prev_op = op;
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40 && (count != 0 || out_valid); c++) step();
    chk("t4_drained", DW'({count, out_valid}), '0);

    // Consumer toggling every cycle over 20 entries.
    sent = 0; rx = 0; out_ready = 1'b0;
    for (int c = 0; c < 400 && rx < 20; c++) begin
      in_valid = (sent < 20); in_data = DW'(32'h200 + sent);
      out_ready = !out_ready;
      #1 if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("t5_data", out_data, DW'(32'h200 + rx));
        rx++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("t5_rx", DW'(rx), DW'(20));

    // Reset the cycle after a read grant: the in-flight entry is dropped.
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(8'h66);
    step();
    in_valid = 1'b0;
    #1 chk("t6_read_grant", DW'({sram_CEN, sram_WEN}), DW'(2'b01));
    step();
    rst = 1'b1;
    step();
    chk("t6_out_valid", DW'(out_valid), '0);
    chk("t6_count", DW'(count), '0);
    chk("t6_err", DW'(err), '0);
    chk("t6_cen", DW'(sram_CEN), DW'(1));
    chk("t6_in_ready", DW'(in_ready), '0);
    rst = 1'b0;
    step(); step(); step();
    chk("t6_after_out_valid", DW'(out_valid), '0);
    chk("t6_after_count", DW'(count), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
